// File: rtl/onp_infix_feeder.sv
// Infix-to-postfix (ONP) token converter using shunting-yard with an operator stack.
// Upstream of M1_ONP; both sides use the STB/ACK/BSY word handshake.
module onp_infix_feeder #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] I_DAT,
  input  logic          I_OP,
  input  logic          I_STB,
  output logic          I_ACK,
  output logic          I_BSY,
  output logic [DW-1:0] O_DAT,
  output logic          O_OP,
  output logic          O_STB,
  input  logic          O_ACK,
  output logic          O_ERR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  localparam logic [7:0] C_ADD = 8'h2B;
  localparam logic [7:0] C_SUB = 8'h2D;
  localparam logic [7:0] C_MUL = 8'h2A;
  localparam logic [7:0] C_DIV = 8'h2F;
  localparam logic [7:0] C_LP  = 8'h28;
  localparam logic [7:0] C_RP  = 8'h29;
  localparam logic [7:0] C_EQ  = 8'h3D;

  typedef enum logic [2:0] {
    IDLE, EMIT, POPOP, POPPAR, FLUSH, DONE, ERR
  } state_t;

  function automatic logic is_arith(input logic [7:0] c);
    return (c == C_ADD) || (c == C_SUB) || (c == C_MUL) || (c == C_DIV);
  endfunction

  function automatic logic [1:0] prec(input logic [7:0] c);
    if ((c == C_MUL) || (c == C_DIV)) return 2'd2;
    else if ((c == C_ADD) || (c == C_SUB)) return 2'd1;
    else return 2'd0;
  endfunction

  state_t          state_q, state_d;
  logic [PW-1:0]   sp_q, sp_d, sp_m1;
  logic [7:0]      stk_q [DEPTH];
  logic [7:0]      tok_q, tok_d, top, code;
  logic            ack_q, ack_d, bsy_q, bsy_d;
  logic            ostb_q, ostb_d, oop_q, oop_d, err_q, err_d;
  logic [DW-1:0]   odat_q, odat_d;
  logic            push_en, cap, full, empty;
  logic [7:0]      push_code;

  assign code  = I_DAT[7:0];
  assign sp_m1 = sp_q - PW'(1);
  assign top   = stk_q[sp_m1[AW-1:0]];
  assign full  = (sp_q == PW'(DEPTH));
  assign empty = (sp_q == '0);
  assign cap   = ((state_q == IDLE) || (state_q == ERR)) && I_STB && !bsy_q;

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    tok_d     = tok_q;
    ack_d     = 1'b0;
    ostb_d    = ostb_q;
    odat_d    = odat_q;
    oop_d     = oop_q;
    err_d     = err_q;
    push_en   = 1'b0;
    push_code = tok_q;
    unique case (state_q)
      IDLE: if (cap) begin
        ack_d = 1'b1;
        if (!I_OP) begin
          odat_d  = I_DAT;
          oop_d   = 1'b0;
          ostb_d  = 1'b1;
          state_d = EMIT;
        end else if (is_arith(code)) begin
          tok_d   = code;
          state_d = POPOP;
        end else if (code == C_LP) begin
          if (full) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            push_en   = 1'b1;
            push_code = code;
            sp_d      = sp_q + PW'(1);
          end
        end else if (code == C_RP) begin
          state_d = POPPAR;
        end else if (code == C_EQ) begin
          state_d = FLUSH;
        end else begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      EMIT: if (O_ACK) begin
        ostb_d  = 1'b0;
        state_d = IDLE;
      end
      POPOP: begin
        // Launching only while O_STB is low guarantees the idle cycle between transfers.
        if (ostb_q) begin
          if (O_ACK) ostb_d = 1'b0;
        end else if (!empty && is_arith(top) && (prec(top) >= prec(tok_q))) begin
          odat_d = DW'(top);
          oop_d  = 1'b1;
          ostb_d = 1'b1;
          sp_d   = sp_m1;
        end else if (full) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          push_en = 1'b1;
          sp_d    = sp_q + PW'(1);
          state_d = IDLE;
        end
      end
      POPPAR: begin
        if (ostb_q) begin
          if (O_ACK) ostb_d = 1'b0;
        end else if (empty) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else if (top == C_LP) begin
          sp_d    = sp_m1;
          state_d = IDLE;
        end else begin
          odat_d = DW'(top);
          oop_d  = 1'b1;
          ostb_d = 1'b1;
          sp_d   = sp_m1;
        end
      end
      FLUSH: begin
        if (ostb_q) begin
          if (O_ACK) ostb_d = 1'b0;
        end else if (empty) begin
          odat_d  = DW'(C_EQ);
          oop_d   = 1'b1;
          ostb_d  = 1'b1;
          state_d = DONE;
        end else if (top == C_LP) begin
          err_d = 1'b1;
          sp_d  = sp_m1;
        end else begin
          odat_d = DW'(top);
          oop_d  = 1'b1;
          ostb_d = 1'b1;
          sp_d   = sp_m1;
        end
      end
      DONE: if (O_ACK) begin
        ostb_d  = 1'b0;
        sp_d    = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      ERR: if (cap) begin
        ack_d = 1'b1;
        if (I_OP && (code == C_EQ)) begin
          sp_d    = '0;
          odat_d  = DW'(C_EQ);
          oop_d   = 1'b1;
          ostb_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // ERR keeps the input open so the discard path can run until '=' arrives.
    bsy_d = cap || ((state_d != IDLE) && (state_d != ERR));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sp_q    <= '0;
      ack_q   <= 1'b0;
      bsy_q   <= 1'b0;
      ostb_q  <= 1'b0;
      odat_q  <= '0;
      oop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      ack_q   <= ack_d;
      bsy_q   <= bsy_d;
      ostb_q  <= ostb_d;
      odat_q  <= odat_d;
      oop_q   <= oop_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    tok_q <= tok_d;
    if (push_en) stk_q[sp_q[AW-1:0]] <= push_code;
  end

  assign I_ACK = ack_q;
  assign I_BSY = bsy_q;
  assign O_DAT = odat_q;
  assign O_OP  = oop_q;
  assign O_STB = ostb_q;
  assign O_ERR = err_q;

endmodule

// File: tb/tb_onp_infix_feeder.sv
// Scoreboard bench for onp_infix_feeder: directed infix expressions, queued postfix expectations.
module tb_onp_infix_feeder;

  localparam logic [31:0] ADD = 32'h2B, SUB = 32'h2D, MUL = 32'h2A;
  localparam logic [31:0] LP = 32'h28, RP = 32'h29, EQ = 32'h3D, PCT = 32'h25;

  logic        clk = 1'b0;
  logic        rst, i_op, i_stb, o_ack, sel;
  logic [31:0] i_dat;
  logic        ack8, bsy8, op8, stb8, err8, ack4, bsy4, op4, stb4, err4;
  logic [31:0] dat8, dat4;
  logic        i_ack_m, i_bsy_m, o_op_m, o_stb_m, o_err_m;
  logic [31:0] o_dat_m;

  typedef struct packed {
    logic        op;
    logic [31:0] dat;
    logic        err;
  } tok_t;
  tok_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int ack_mode = 0;

  always #5 clk = ~clk;

  onp_infix_feeder #(.DW(32), .DEPTH(8)) dut8 (
    .CLK(clk), .RST(rst), .I_DAT(i_dat), .I_OP(i_op), .I_STB(i_stb & ~sel),
    .I_ACK(ack8), .I_BSY(bsy8), .O_DAT(dat8), .O_OP(op8), .O_STB(stb8),
    .O_ACK(o_ack), .O_ERR(err8)
  );

  onp_infix_feeder #(.DW(32), .DEPTH(4)) dut4 (
    .CLK(clk), .RST(rst), .I_DAT(i_dat), .I_OP(i_op), .I_STB(i_stb & sel),
    .I_ACK(ack4), .I_BSY(bsy4), .O_DAT(dat4), .O_OP(op4), .O_STB(stb4),
    .O_ACK(o_ack), .O_ERR(err4)
  );

  assign i_ack_m = sel ? ack4 : ack8;
  assign i_bsy_m = sel ? bsy4 : bsy8;
  assign o_dat_m = sel ? dat4 : dat8;
  assign o_op_m  = sel ? op4  : op8;
  assign o_stb_m = sel ? stb4 : stb8;
  assign o_err_m = sel ? err4 : err8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_tok(input logic op, input logic [31:0] d, input logic e);
    tok_t t;
    t.op = op; t.dat = d; t.err = e;
    exp_q.push_back(t);
  endtask

  task automatic send(input logic op, input logic [31:0] d);
    int n;
    @(negedge clk);
    i_op = op; i_dat = d; i_stb = 1'b1; n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!i_ack_m && n < 300);
    i_stb = 1'b0;
    chk("ack_seen", {31'b0, i_ack_m}, 32'd1);
    @(posedge clk); #1;
    chk("ack_width", {31'b0, i_ack_m}, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_stb_m || i_bsy_m) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    chk("idle_bsy", {31'b0, i_bsy_m}, 32'd0);
    exp_q.delete();
  endtask

  // Output monitor: pops the scoreboard on every transfer, checks stability while stalled.
  initial begin
    logic        held_v;
    logic [31:0] held_dat;
    logic        held_op;
    tok_t        e;
    held_v = 1'b0; held_dat = '0; held_op = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && o_stb_m) begin
        if (held_v) begin
          chk("stall_dat", o_dat_m, held_dat);
          chk("stall_op", {31'b0, o_op_m}, {31'b0, held_op});
        end
        if (o_ack) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_token: got op=%0d dat=%0h, expected none", o_op_m, o_dat_m);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_op", {31'b0, o_op_m}, {31'b0, e.op});
            chk("xfer_dat", o_dat_m, e.dat);
            chk("xfer_err", {31'b0, o_err_m}, {31'b0, e.err});
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1; held_dat = o_dat_m; held_op = o_op_m;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // O_ACK driver: 0 = tied high, 1 = low for 10 cycles before each transfer, 2 = held low.
  initial begin
    int cnt;
    cnt = 0; o_ack = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ack_mode)
        0: o_ack = 1'b1;
        1: if (o_stb_m) begin
             if (cnt >= 10) begin o_ack = 1'b1; cnt = 0; end
             else begin o_ack = 1'b0; cnt++; end
           end else begin
             o_ack = 1'b0; cnt = 0;
           end
        default: o_ack = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_op = 1'b0; i_dat = '0; i_stb = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack8}, 32'd0);
    chk("rst_bsy", {31'b0, bsy8}, 32'd0);
    chk("rst_stb", {31'b0, stb8}, 32'd0);
    chk("rst_dat", dat8, 32'd0);
    chk("rst_op", {31'b0, op8}, 32'd0);
    chk("rst_err", {31'b0, err8}, 32'd0);
    chk("rst_err4", {31'b0, err4}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // 3 + 4 * 2 =
    expect_tok(0, 3, 0); expect_tok(0, 4, 0); expect_tok(0, 2, 0);
    expect_tok(1, MUL, 0); expect_tok(1, ADD, 0); expect_tok(1, EQ, 0);
    send(0, 3); send(1, ADD); send(0, 4); send(1, MUL); send(0, 2); send(1, EQ);
    drain();
    chk("t1_err", {31'b0, o_err_m}, 32'd0);

    // ( 1 + 2 ) * 3 =
    expect_tok(0, 1, 0); expect_tok(0, 2, 0); expect_tok(1, ADD, 0);
    expect_tok(0, 3, 0); expect_tok(1, MUL, 0); expect_tok(1, EQ, 0);
    send(1, LP); send(0, 1); send(1, ADD); send(0, 2); send(1, RP);
    send(1, MUL); send(0, 3); send(1, EQ);
    drain();

    // 8 - 3 - 2 = with stalled consumer
    ack_mode = 1;
    expect_tok(0, 8, 0); expect_tok(0, 3, 0); expect_tok(1, SUB, 0);
    expect_tok(0, 2, 0); expect_tok(1, SUB, 0); expect_tok(1, EQ, 0);
    send(0, 8); send(1, SUB); send(0, 3); send(1, SUB); send(0, 2); send(1, EQ);
    drain();
    ack_mode = 0;

    // ) 5 =
    expect_tok(1, EQ, 1);
    send(1, RP);
    chk("rp_err", {31'b0, o_err_m}, 32'd1);
    send(0, 5); send(1, EQ);
    drain();
    chk("rp_err_clr", {31'b0, o_err_m}, 32'd0);

    // ( 5 =
    expect_tok(0, 5, 0); expect_tok(1, EQ, 1);
    send(1, LP); send(0, 5); send(1, EQ);
    drain();
    chk("lp_err_clr", {31'b0, o_err_m}, 32'd0);

    // unknown operator then '='
    expect_tok(1, EQ, 1);
    send(1, PCT);
    chk("unk_err", {31'b0, o_err_m}, 32'd1);
    send(0, 9); send(1, EQ);
    drain();

    // DEPTH=4 overflow
    sel = 1'b1;
    send(1, LP); send(1, LP); send(1, LP); send(1, LP);
    chk("d4_noerr", {31'b0, o_err_m}, 32'd0);
    expect_tok(1, EQ, 1);
    send(1, LP);
    chk("d4_ovf_err", {31'b0, o_err_m}, 32'd1);
    send(0, 1); send(1, EQ);
    drain();
    chk("d4_err_clr", {31'b0, o_err_m}, 32'd0);
    expect_tok(0, 1, 0); expect_tok(0, 2, 0); expect_tok(1, ADD, 0); expect_tok(1, EQ, 0);
    send(0, 1); send(1, ADD); send(0, 2); send(1, EQ);
    drain();
    sel = 1'b0;

    // reset while O_STB is pending, with a '(' left on the stack
    ack_mode = 2;
    send(1, LP); send(0, 7);
    chk("pre_rst_stb", {31'b0, o_stb_m}, 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_stb", {31'b0, o_stb_m}, 32'd0);
    chk("mid_rst_dat", o_dat_m, 32'd0);
    chk("mid_rst_op", {31'b0, o_op_m}, 32'd0);
    chk("mid_rst_ack", {31'b0, i_ack_m}, 32'd0);
    chk("mid_rst_bsy", {31'b0, i_bsy_m}, 32'd0);
    chk("mid_rst_err", {31'b0, o_err_m}, 32'd0);
    @(negedge clk); rst = 1'b0;
    ack_mode = 0;
    expect_tok(0, 2, 0); expect_tok(0, 3, 0); expect_tok(1, ADD, 0); expect_tok(1, EQ, 0);
    send(0, 2); send(1, ADD); send(0, 3); send(1, EQ);
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
